pow_root_iter: RTL
==================

Name: pow_root_iter

Overview:
- Inverse companion to the pipelined power unit: takes a 64-bit value y and returns floor(y^(1/2^LEVELS)), i.e. the 8th root for LEVELS=3.
- Also flags whether y is an exact 2^LEVELS-th power.
- Iterative, area-lean engine: one bit-serial restoring square root applied LEVELS times back to back.
- Sits downstream of the power unit in checker and recovery paths, with valid/ready handshakes on both sides.

Parameters:
- LEVELS, 3, number of chained square roots; result = floor of y^(1/2^LEVELS).
- DATA_W, 64, input width; must be divisible by 2^LEVELS; LEVELS >= 1.
- OUT_W, DATA_W>>LEVELS (8), result width; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- i_data  input  DATA_W  radicand y.
- i_valid  input  1  i_data valid.
- o_ready  output  1  engine can accept input (IDLE only).
- o_valid  output  1  result valid; held until accepted.
- o_root  output  OUT_W  floor(y^(1/2^LEVELS)).
- o_exact  output  1  1 if y == o_root^(2^LEVELS).
- i_ready  input  1  downstream accepts the result.

Behaviour:
- Reset, sampled at a rising clk with rst=1:
  - state IDLE; o_ready=1; o_valid=0; o_root=0; o_exact=0.
  - Internal radicand, remainder, root, level and iteration counters are cleared.
  - rst overrides everything, in any state, including mid-calculation; the in-flight operation is discarded with no output.
- States: IDLE, CALC, DONE.
- IDLE:
  - o_ready=1.
  - If i_valid=1 on an edge, i_data is latched as the level-0 radicand; level=0, iteration=0, exact accumulator=1; go to CALC.
  - If i_valid=0, stay in IDLE.
- CALC:
  - o_ready=0; i_valid and i_data are ignored.
  - Level l operates on radicand width W_l = DATA_W>>l and runs W_l/2 iterations.
  - Each iteration is one clk cycle and produces one root bit, MSB first (restoring: shift in 2 radicand bits, trial-subtract (root<<2)|1, keep the result if non-negative).
  - On the last iteration of level l:
    - exact accumulator &= (final remainder == 0).
    - The W_l/2-bit root becomes the level l+1 radicand, zero-extended as needed; level++.
  - After the last iteration of level LEVELS-1, go to DONE.
- Iteration count: N_IT = sum over l=0..LEVELS-1 of DATA_W>>(l+1), which is 32+16+8 = 56 for the defaults.
- Latency: if the input is accepted at the edge ending cycle k, CALC occupies cycles k+1..k+N_IT and o_valid=1 first in cycle k+N_IT+1 (k+57 for defaults).
- DONE:
  - o_valid=1; o_root and o_exact are stable and must not change while o_valid=1 and i_ready=0.
  - o_ready=0.
  - On an edge with i_ready=1, the transfer completes: o_valid=0 in the next cycle, state IDLE, o_ready=1.
  - No input acceptance in the same cycle as an output transfer.
  - Minimum spacing between input acceptances: N_IT+2 cycles.
- o_root and o_exact may hold stale values while o_valid=0; the bench must not check them then.
- Arithmetic:
  - Floor at every level; a nested floor-sqrt chain equals the floor of the 2^LEVELS-th root, so no correction step is needed.
  - Remainder register width W_l/2+2 is sufficient; no overflow on y = 2^DATA_W-1.
  - o_exact=1 iff every level's remainder was 0, equivalently iff y is a perfect 2^LEVELS-th power.
- y=0 gives root 0, exact 1; y=1 gives root 1, exact 1.
- i_ready may be held high continuously; the result then lasts exactly one cycle in DONE.

Test Plan:
- Accept y=0, then y=1 (i_ready=1 throughout) -> o_root=0, o_exact=1; then o_root=1, o_exact=1; each o_valid first high exactly 57 cycles after acceptance.
- y=10^16 (100^8) -> o_root=100, o_exact=1. y=10^16+1 -> o_root=100, o_exact=0. y=256=2^8 (2^1 raised to 8 is 256) -> o_root=2, o_exact=1.
- y=2^64-1 -> o_root=255, o_exact=0. y=255^8 -> o_root=255, o_exact=1.
- Backpressure: hold i_ready=0 for 10 cycles after o_valid rises -> o_valid, o_root and o_exact are stable and o_ready=0 throughout; raise i_ready -> o_valid=0 and o_ready=1 the next cycle.
- Keep i_valid=1 with changing i_data during CALC -> those inputs are ignored and the result reflects only the first accepted value; a second accept occurs no earlier than 58 cycles after the first.
- Assert rst for 1 cycle at CALC cycle 20 -> the next cycle shows o_ready=1, o_valid=0, o_root=0, o_exact=0; a new y=6561 (3^8) is then accepted -> o_root=3, o_exact=1 after 57 cycles.

Source files
------------

// File: rtl/pow_root_iter.sv
// Iterative 2^LEVELS-th root: one bit-serial restoring square root reused LEVELS
// times, each level's root feeding the next level's radicand. Valid/ready on both sides.
module pow_root_iter #(
  parameter  int LEVELS = 3,
  parameter  int DATA_W = 64,
  localparam int OUT_W  = DATA_W >> LEVELS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_valid,
  output logic [OUT_W-1:0]  o_root,
  output logic              o_exact,
  input  logic              i_ready
);

  localparam int HALF_W = DATA_W / 2;
  localparam int RW     = HALF_W + 2;
  localparam int IT_W   = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam int LV_W   = $clog2(LEVELS + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] rad;      // radicand, left-aligned; top two bits consumed per cycle
  logic [RW-1:0]     rem;
  logic [HALF_W-1:0] root;
  logic [IT_W-1:0]   iter;
  logic [LV_W-1:0]   level;
  logic              exact_acc;

  logic [RW-1:0]     rem_sh;
  logic [RW-1:0]     trial;
  logic              fits;
  logic [RW-1:0]     rem_nxt;
  logic [HALF_W-1:0] root_nxt;
  logic [DATA_W-1:0] rad_load;
  logic              last_iter;
  logic              last_level;
  logic              exact_nxt;
  int                half_w;

  // One restoring step: bring down two radicand bits, trial-subtract 4*root+1.
  // NOTE: every always_comb output gets a value on every path, so no latches form.
  always_comb begin
    half_w     = DATA_W >> (int'(level) + 1);
    rem_sh     = {rem[RW-3:0], rad[DATA_W-1 -: 2]};
    trial      = {root, 2'b01};
    fits       = (rem_sh >= trial);
    rem_nxt    = fits ? (rem_sh - trial) : rem_sh;
    root_nxt   = {root[HALF_W-2:0], fits};
    last_iter  = (int'(iter) == half_w - 1);
    last_level = (int'(level) == LEVELS - 1);
    exact_nxt  = exact_acc & (rem_nxt == '0);
    // Next level's radicand is half_w bits wide; align it to the top of rad.
    rad_load   = {{(DATA_W-HALF_W){1'b0}}, root_nxt} << (DATA_W - half_w);
  end

  assign o_ready = (state == ST_IDLE);
  assign o_valid = (state == ST_DONE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rad       <= '0;
      rem       <= '0;
      root      <= '0;
      iter      <= '0;
      level     <= '0;
      exact_acc <= 1'b0;
      o_root    <= '0;
      o_exact   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            rad       <= i_data;
            rem       <= '0;
            root      <= '0;
            iter      <= '0;
            level     <= '0;
            exact_acc <= 1'b1;
            state     <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (last_iter) begin
            exact_acc <= exact_nxt;
            rem       <= '0;
            root      <= '0;
            iter      <= '0;
            rad       <= rad_load;
            level     <= level + 1'b1;
            if (last_level) begin
              o_root  <= root_nxt[OUT_W-1:0];
              o_exact <= exact_nxt;
              state   <= ST_DONE;
            end
          end else begin
            rem  <= rem_nxt;
            root <= root_nxt;
            rad  <= {rad[DATA_W-3:0], 2'b00};
            iter <= iter + 1'b1;
          end
        end
        ST_DONE: begin
          if (i_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
